// File: rtl/obj_spawner.sv
// obj_spawner: scrolls the world, spawns LFSR obstacles into the object FIFO, retires passed ones.
// Optional OBJ_SPAWNER_STATS_EN adds saturating spawn_count / skip_count outputs.
module obj_spawner #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter logic [11:0] HORIZON     = 12'd1024,
    parameter logic [11:0] MIN_GAP     = 12'd64,
    parameter logic [11:0] PASS_MARGIN = 12'd32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  frame_tick,
    input  logic [3:0]            speed,
    input  logic [15:0]           front_obj,
    input  logic [ADDR_WIDTH:0]   num,
    output logic                  push,
    output logic                  pop,
    output logic [15:0]           wr_obj,
    output logic [11:0]           scroll_pos,
`ifdef OBJ_SPAWNER_STATS_EN
    output logic [15:0]           spawn_count,
    output logic [15:0]           skip_count,
`endif
    output logic                  running
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_ADVANCE,
        S_RETIRE,
        S_RWAIT,
        S_SPAWN
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_scroll;
    logic [11:0] r_gap_acc;
    logic [11:0] r_next_gap;
    logic [15:0] r_lfsr;
    logic        r_tick_pend;
    logic        r_push;
    logic        r_pop;
    logic [15:0] r_wr_obj;

    logic        w_do_adv;
    logic        w_do_pop;
    logic        w_do_push;
    logic        w_skip;
    logic [11:0] w_diff;
    logic        w_pass;
    logic        w_full;
    logic        w_gap_ok;
    logic [12:0] w_gap_sum;
    logic [11:0] w_gap_sat;
    logic [1:0]  w_lane;
    logic [1:0]  w_type;
    logic [11:0] w_spawn_pos;
    logic [15:0] w_spawn_word;
    logic [15:0] w_lfsr_next;
    logic [11:0] w_new_gap;
    logic        w_unused_bits;

    // diff in [PASS_MARGIN, 2048) means the object is behind the player
    assign w_diff = r_scroll - front_obj[11:0];
    assign w_pass = (num != '0) && (w_diff >= PASS_MARGIN) && !w_diff[11];

    assign w_full   = (num >= DEPTH);
    assign w_gap_ok = (r_gap_acc >= r_next_gap);

    assign w_gap_sum = {1'b0, r_gap_acc} + {9'b0, speed};
    assign w_gap_sat = w_gap_sum[12] ? 12'hFFF : w_gap_sum[11:0];

    assign w_lane       = (r_lfsr[1:0] == 2'b11) ? 2'b01 : r_lfsr[1:0];
    assign w_type       = (r_lfsr[3:2] == 2'b11) ? 2'b00 : r_lfsr[3:2];
    assign w_spawn_pos  = r_scroll + HORIZON;
    assign w_spawn_word = {w_type, w_lane, w_spawn_pos};

    // Fibonacci taps 16,14,13,11 in shift-right form
    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5],
                          r_lfsr[15:1]};
    assign w_new_gap   = MIN_GAP + {6'b0, r_lfsr[9:4]};

    assign w_unused_bits = ^front_obj[15:12];

    always_comb begin
        w_next    = r_state;
        w_do_adv  = 1'b0;
        w_do_pop  = 1'b0;
        w_do_push = 1'b0;
        w_skip    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (halt) begin
                    w_next = S_IDLE;
                end else if (r_tick_pend || frame_tick) begin
                    w_next = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                w_do_adv = 1'b1;
                w_next   = S_RETIRE;
            end
            S_RETIRE: begin
                if (w_pass) begin
                    w_do_pop = 1'b1;
                    w_next   = S_RWAIT;
                end else begin
                    w_next = S_SPAWN;
                end
            end
            S_RWAIT: begin
                w_next = S_RETIRE;
            end
            S_SPAWN: begin
                w_next = S_RUN;
                if (w_gap_ok) begin
                    if (w_full) begin
                        w_skip = 1'b1;
                    end else begin
                        w_do_push = 1'b1;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_scroll    <= 12'd0;
            r_gap_acc   <= 12'd0;
            r_next_gap  <= MIN_GAP;
            r_lfsr      <= LFSR_SEED;
            r_tick_pend <= 1'b0;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_wr_obj    <= 16'd0;
        end else begin
            r_state <= w_next;
            r_push  <= w_do_push;
            r_pop   <= w_do_pop;

            // entering ADVANCE consumes the pending tick; extra ticks are dropped
            if (r_state == S_RUN && w_next == S_ADVANCE) begin
                r_tick_pend <= 1'b0;
            end else if (frame_tick && r_state != S_IDLE) begin
                r_tick_pend <= 1'b1;
            end

            if (w_do_adv) begin
                r_scroll  <= r_scroll + {8'b0, speed};
                r_gap_acc <= w_gap_sat;
            end

            if (w_do_push) begin
                r_wr_obj   <= w_spawn_word;
                r_gap_acc  <= 12'd0;
                r_next_gap <= w_new_gap;
                r_lfsr     <= w_lfsr_next;
            end
        end
    end

`ifdef OBJ_SPAWNER_STATS_EN
    logic [15:0] r_spawn_cnt;
    logic [15:0] r_skip_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_spawn_cnt <= 16'd0;
            r_skip_cnt  <= 16'd0;
        end else begin
            if (w_do_push && r_spawn_cnt != 16'hFFFF) begin
                r_spawn_cnt <= r_spawn_cnt + 16'd1;
            end
            if (w_skip && r_skip_cnt != 16'hFFFF) begin
                r_skip_cnt <= r_skip_cnt + 16'd1;
            end
        end
    end

    assign spawn_count = r_spawn_cnt;
    assign skip_count  = r_skip_cnt;
`endif

    assign push       = r_push;
    assign pop        = r_pop;
    assign wr_obj     = r_wr_obj;
    assign scroll_pos = r_scroll;
    assign running    = (r_state != S_IDLE);

endmodule

// File: tb/tb_obj_spawner.sv
// tb_obj_spawner: scoreboard bench with a frame-level reference model and a FIFO model.
// Expected strobes are queued at tick time; a negedge monitor pops and compares them.
module tb_obj_spawner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        frame_tick = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [15:0] front_obj = 16'd0;
    logic [4:0]  num = 5'd0;

    logic        push;
    logic        pop;
    logic [15:0] wr_obj;
    logic [11:0] scroll_pos;
    logic        running;
    logic        push2;
    logic        pop2;
    logic [15:0] wr_obj2;
    logic [11:0] scroll2;
    logic        running2;
`ifdef OBJ_SPAWNER_STATS_EN
    logic [15:0] spawn_count;
    logic [15:0] skip_count;
    logic [15:0] spawn_count2;
    logic [15:0] skip_count2;
`endif

    always #5 clk = ~clk;

    obj_spawner u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .frame_tick (frame_tick),
        .speed      (speed),
        .front_obj  (front_obj),
        .num        (num),
        .push       (push),
        .pop        (pop),
        .wr_obj     (wr_obj),
        .scroll_pos (scroll_pos),
`ifdef OBJ_SPAWNER_STATS_EN
        .spawn_count(spawn_count),
        .skip_count (skip_count),
`endif
        .running    (running)
    );

    obj_spawner #(.LFSR_SEED(16'h000F)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .frame_tick (frame_tick),
        .speed      (speed),
        .front_obj  (front_obj),
        .num        (num),
        .push       (push2),
        .pop        (pop2),
        .wr_obj     (wr_obj2),
        .scroll_pos (scroll2),
`ifdef OBJ_SPAWNER_STATS_EN
        .spawn_count(spawn_count2),
        .skip_count (skip_count2),
`endif
        .running    (running2)
    );

    typedef struct packed {
        logic        is_push;
        logic [15:0] word;
        logic [11:0] sc;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] bq[$];
    logic [15:0] pl_q[$];
    int          pl_seq = 0;
    int          pl_seen = 0;

    int          m_scroll;
    int          m_gap;
    int          m_next_gap;
    int          m_lfsr;
    logic [15:0] mq[$];

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_push = 0;
    int          n_pop = 0;
    int          n_push2 = 0;
    int          push_cyc = 0;
    int          tick_cyc = 0;
    int          pop_cyc[$];
    logic [15:0] last_word = 16'd0;
    logic [15:0] first_w2 = 16'd0;

    task automatic check(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    function automatic int lfsr_step(input int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return ((l >> 1) | (b << 15)) & 16'hFFFF;
    endfunction

    function automatic logic [15:0] make_word();
        int lane;
        int typ;
        int pos;
        lane = m_lfsr % 4;
        if (lane == 3) lane = 1;
        typ = (m_lfsr / 4) % 4;
        if (typ == 3) typ = 0;
        pos = (m_scroll + 1024) % 4096;
        return 16'(typ * 16384 + lane * 4096 + pos);
    endfunction

    // One whole frame: advance, retire everything passed, then try to spawn.
    function automatic int model_frame(input int spd);
        int          np;
        int          p;
        int          diff;
        logic [11:0] sc;
        logic [15:0] w;
        np = 0;
        m_scroll = (m_scroll + spd) % 4096;
        m_gap = m_gap + spd;
        if (m_gap > 4095) m_gap = 4095;
        sc = 12'(m_scroll);
        while (mq.size() > 0) begin
            p = int'(mq[0][11:0]);
            diff = (m_scroll - p + 4096) % 4096;
            if (diff < 32 || diff >= 2048) break;
            exp_q.push_back('{1'b0, 16'h0, sc});
            void'(mq.pop_front());
            np++;
        end
        if (m_gap >= m_next_gap && mq.size() < 16) begin
            w = make_word();
            exp_q.push_back('{1'b1, w, sc});
            mq.push_back(w);
            m_gap = 0;
            m_next_gap = 64 + ((m_lfsr >> 4) & 63);
            m_lfsr = lfsr_step(m_lfsr);
        end
        return np;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            if (push && pop) begin
                check("push_pop_overlap", 1, 0);
            end
            if (push || pop) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, push, pop}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind_push", int'(push), int'(e.is_push));
                    check("ev_scroll", int'(scroll_pos), int'(e.sc));
                    if (e.is_push) begin
                        check("ev_word", int'(wr_obj), int'(e.word));
                    end
                end
            end
            if (pop) begin
                n_pop++;
                pop_cyc.push_back(cyc);
                if (bq.size() > 0) void'(bq.pop_front());
            end
            if (push) begin
                n_push++;
                push_cyc = cyc;
                last_word = wr_obj;
                bq.push_back(wr_obj);
            end
            if (push2) begin
                n_push2++;
                if (n_push2 == 1) first_w2 = wr_obj2;
            end
        end
        if (pl_seq != pl_seen) begin
            bq = pl_q;
            pl_seen = pl_seq;
        end
        num = 5'(bq.size());
        front_obj = (bq.size() > 0) ? bq[0] : 16'd0;
    end

    task automatic commit_fifo();
        pl_q = mq;
        @(posedge clk);
        #1 pl_seq++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_scroll = 0;
        m_gap = 0;
        m_next_gap = 64;
        m_lfsr = 16'hACE1;
        mq.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        frame_tick = 1'b0;
        speed = 4'd0;
        model_reset();
        n_push = 0;
        n_pop = 0;
        #1;
        check("rst_push", int'(push), 0);
        check("rst_pop", int'(pop), 0);
        check("rst_wr_obj", int'(wr_obj), 0);
        check("rst_running", int'(running), 0);
        check("rst_scroll", int'(scroll_pos), 0);
        commit_fifo();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // burst > 1 sends back-to-back ticks: one pends, the rest are dropped
    task automatic tick(input int spd, input int burst);
        int np;
        int nf;
        @(negedge clk);
        speed = 4'(spd);
        frame_tick = 1'b1;
        tick_cyc = cyc;
        nf = (burst > 1) ? 2 : 1;
        np = model_frame(spd);
        if (nf == 2) np += model_frame(spd);
        repeat (burst) @(negedge clk);
        frame_tick = 1'b0;
        repeat (nf * 6 + 2 * np + 4) @(negedge clk);
    endtask

    task automatic halt_cycle();
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("halt_idle", int'(running), 0);
        do_start();
    endtask

    task automatic setup_multi();
        do_reset();
        do_start();
        for (int i = 0; i < 13; i++) tick(15, 1);
        mq.push_front(16'd30);
        mq.push_front(16'd20);
        mq.push_front(16'd10);
        commit_fifo();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np0;
        int d;
        int r;
        int found;

        do_reset();
        do_start();
        check("run_after_start", int'(running), 1);
        for (int i = 0; i < 16; i++) tick(4, 1);
        check("a_push_count", n_push, 1);
        check("a_word_pos", int'(last_word[11:0]), 1088);
        check("a_scroll", int'(scroll_pos), 64);
        check("a_latency", push_cyc - tick_cyc, 4);
        check("a_seed_push", n_push2, 1);
        check("a_seed_lane", int'(first_w2[13:12]), 1);
        check("a_seed_type", int'(first_w2[15:14]), 0);

        do_reset();
        do_start();
        mq.push_back(16'd100);
        commit_fifo();
        for (int i = 0; i < 8; i++) tick(15, 1);
        tick(11, 1);
        check("b_scroll_131", int'(scroll_pos), 131);
        check("b_no_pop_131", n_pop, 0);
        tick(1, 1);
        check("b_pop_132", n_pop, 1);

        setup_multi();
        pop_cyc.delete();
        tick(5, 1);
        check("c_scroll", int'(scroll_pos), 200);
        check("c_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("c_gap01", pop_cyc[1] - pop_cyc[0], 2);
            check("c_gap12", pop_cyc[2] - pop_cyc[1], 2);
        end

        setup_multi();
        @(negedge clk);
        speed = 4'd5;
        frame_tick = 1'b1;
        void'(model_frame(5));
        @(negedge clk);
        frame_tick = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (pop) found = 1;
        end
        check("d_pop_seen", found, 1);
        #1 reset = 1'b0;
        #1;
        check("d_rst_push", int'(push), 0);
        check("d_rst_pop", int'(pop), 0);
        check("d_rst_wr_obj", int'(wr_obj), 0);
        check("d_rst_running", int'(running), 0);
        check("d_rst_scroll", int'(scroll_pos), 0);
        model_reset();
        commit_fifo();
        @(negedge clk);
        reset = 1'b1;
        np0 = n_push + n_pop;
        do_start();
        repeat (10) @(negedge clk);
        check("d_no_strobe", n_push + n_pop - np0, 0);

        do_reset();
        do_start();
        repeat (16) mq.push_back(16'd1500);
        commit_fifo();
        for (int i = 0; i < 8; i++) tick(8, 1);
        check("e_full_no_push", n_push, 0);
`ifdef OBJ_SPAWNER_STATS_EN
        check("e_skip_count", int'(skip_count), 1);
`endif
        void'(mq.pop_back());
        commit_fifo();
        tick(0, 1);
        check("e_retry_push", n_push, 1);
        check("e_scroll", int'(scroll_pos), 64);

        do_reset();
        do_start();
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) halt_cycle();
            tick($urandom_range(0, 15), (r == 1) ? 3 : ((r == 2) ? 2 : 1));
        end
        while (m_scroll != 4094) begin
            d = (4094 - m_scroll + 4096) % 4096;
            tick((d > 15) ? 15 : d, 1);
        end
        check("f_scroll_4094", int'(scroll_pos), 4094);
        mq.push_front(16'd4080);
        commit_fifo();
        np0 = n_pop;
        tick(4, 1);
        check("f_wrap_scroll", int'(scroll_pos), 2);
        check("f_wrap_nopop", n_pop - np0, 0);
        tick(4, 1);
        tick(4, 1);
        tick(4, 1);
        check("f_nopop_30", n_pop - np0, 0);
        tick(2, 1);
        check("f_pop_32", int'((n_pop - np0) >= 1), 1);

        repeat (5) @(negedge clk);
        check("exp_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/obj_spawner.md
Name: obj_spawner

Overview:
- Upstream producer for the 16-bit object FIFO (front-indexed, push/pop, depth 2**ADDR_WIDTH) that holds obstacles for the renderer.
- Owns the world scroll position, advanced once per frame tick.
- Spawns pseudo-random obstacles ahead of the player and pushes them into the FIFO.
- Pops the front object once the player has passed it.

Parameters:
- ADDR_WIDTH, 4, log2 of the object FIFO depth; must match the FIFO instance.
- HORIZON, 12'd1024, spawn distance ahead of scroll_pos; must be < 2048.
- MIN_GAP, 12'd64, minimum scroll distance between spawns.
- PASS_MARGIN, 12'd32, distance behind scroll_pos at which the front object is retired.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- start  in  1  pulse; IDLE -> RUN.
- halt  in  1  level; forces return to IDLE at the next RUN state.
- frame_tick  in  1  one-cycle pulse per video frame.
- speed  in  4  scroll increment per frame; sampled in ADVANCE.
- front_obj  in  16  FIFO rd_obj at rd_index 0.
- num  in  ADDR_WIDTH+1  FIFO occupancy.
- push  out  1  FIFO push strobe.
- pop  out  1  FIFO pop strobe.
- wr_obj  out  16  object word; valid while push=1.
- scroll_pos  out  12  current world position, wraps mod 4096.
- running  out  1  high in every state except IDLE.

Behaviour:
- Object word fields:
  - [11:0] position = scroll_pos + HORIZON, mod 4096.
  - [13:12] lane = lfsr[1:0], with 2'b11 mapped to 2'b01.
  - [15:14] type = lfsr[3:2], with 2'b11 mapped to 2'b00.
- Reset (reset=0, asynchronous) clears:
  - state=IDLE; scroll_pos=0; gap_acc=0; next_gap=MIN_GAP; lfsr=LFSR_SEED.
  - tick_pend=0; push=0; pop=0; wr_obj=0; running=0.
  - Reset mid-operation aborts immediately; no partial push or pop follows.
- Outputs: push, pop and wr_obj are registered. Each strobe is high for exactly one cycle; push and pop are never high in the same cycle.
- tick_pend: set by frame_tick in any non-IDLE state, cleared on entering ADVANCE. A tick arriving while tick_pend=1 is dropped. Ticks in IDLE are ignored.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: halt=1 -> IDLE (halt has priority over a pending tick). Else tick_pend or frame_tick -> ADVANCE.
  - ADVANCE (1 cycle):
    - scroll_pos += speed, mod 4096.
    - gap_acc = min(gap_acc + speed, 12'hFFF).
    - -> RETIRE.
  - RETIRE:
    - diff = scroll_pos - front_obj[11:0], mod 4096.
    - If num != 0 and PASS_MARGIN <= diff < 2048: register pop, -> RWAIT.
    - Else -> SPAWN.
  - RWAIT: one cycle so front_obj and num reflect the pop; -> RETIRE. Multiple objects may retire per frame, one per 2 cycles.
  - SPAWN:
    - If gap_acc >= next_gap and num < 2**ADDR_WIDTH: register push with wr_obj built from the current lfsr and scroll_pos; gap_acc=0; next_gap = MIN_GAP + {6'b0, lfsr[9:4]}; lfsr steps once.
    - If the FIFO is full: no push; gap_acc holds (saturated), so the spawn is retried next frame.
    - -> RUN.
- Latency: frame_tick sampled in RUN at cycle N gives ADVANCE at N+1, RETIRE at N+2. With no retirements, the push strobe is high at N+4.
- Wrap-around: all position arithmetic is modulo 4096. The diff < 2048 window distinguishes objects ahead of the player from objects behind.
- No frame processing occurs in IDLE; scroll_pos holds its value.

Optional Feature:
- Macro OBJ_SPAWNER_STATS_EN.
- Defined: adds output spawn_count[15:0], the number of pushes, and output skip_count[15:0], the number of frames whose spawn was suppressed by a full FIFO. Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, start, speed=4, 16 frame_ticks, num=0 -> exactly one push, after tick 16, with wr_obj[11:0]=1088 and scroll_pos=64.
- Lane/type mapping: force lfsr[3:0]=4'b1111 via seed 16'h000F -> first push has lane=2'b01, type=2'b00.
- Retire: front_obj[11:0]=100, num=1, scroll_pos reaching 132 -> pop pulses for 1 cycle at that frame's RETIRE; at scroll_pos 131, no pop.
- Multi-retire: num=3 with positions 10, 20, 30 and scroll_pos=200 -> 3 pops in one frame, spaced 2 cycles apart, then SPAWN.
- Full FIFO: num=16, gap reached -> no push, gap_acc holds; next frame with num=15 -> push occurs.
- Wrap: scroll_pos=4094, speed=4 -> scroll_pos=2. Front object at 4080 -> diff=18, no pop until diff >= 32. Separately, assert reset low mid-RWAIT -> all outputs 0 immediately.
